phase_align_ctrl: RTL and testbench
===================================

# phase_align_ctrl

Sequencing controller that phase-aligns the three ECG processing streams: FIR bandpass (BP), 75-point moving average (MA), and smoothed 2nd derivative (D2). It sits after the per-stream output FIFOs in the ECG block design and gates their `tready` lines. During start-up it primes the FIFOs so that BP is held back BP_DELAY samples and MA is held back MA_DELAY samples relative to D2. After priming it pops all three streams in lockstep and flags loss of alignment.

## Interface
- BP_DELAY, 350, BP lag behind D2, in input-sample handshakes
- MA_DELAY, 43, MA lag behind D2, in input-sample handshakes; must be < BP_DELAY
- CNT_W, 10, sample counter width; 2^CNT_W > BP_DELAY
- SKEW_LIMIT, 1000, consecutive partial-valid cycles tolerated in RUN
- SKEW_W, 10, skew counter width; 2^SKEW_W > SKEW_LIMIT

Ports:
- sys_clock  in  1  single clock for the block
- reset  in  1  synchronous, active-high
- enable  in  1  level; 1 = run alignment, 0 = return to IDLE
- src_tvalid  in  1  monitor of the ADC-sample stream entering the filters
- src_tready  in  1  monitor of the ADC-sample stream entering the filters
- bp_tvalid  in  1  BP FIFO valid
- bp_tready  out  1  BP FIFO ready
- ma_tvalid  in  1  MA FIFO valid
- ma_tready  out  1  MA FIFO ready
- d2_tvalid  in  1  D2 FIFO valid
- d2_tready  out  1  D2 FIFO ready
- aligned_valid  out  1  one-cycle pulse; the three stream heads are being consumed as one aligned triple
- state  out  2  current FSM state
- skew_err  out  1  sticky; set on entry to FAULT
- sample_cnt  out  CNT_W  source handshakes counted in FILL

## Operation
The FSM has four states: IDLE=0, FILL=1, RUN=2, FAULT=3.

- **IDLE**
  - All treadys 0; sample_cnt held at 0.
  - enable=1 → FILL.
- **FILL**
  - sample_cnt increments on each src_tvalid&src_tready. It saturates at BP_DELAY.
  - d2_tready=1: D2 filter-transient samples are discarded.
  - ma_tready=1 while sample_cnt < BP_DELAY−MA_DELAY, then 0. The FIFO accumulates MA_DELAY samples.
  - bp_tready=0 throughout. The FIFO accumulates BP_DELAY samples.
  - sample_cnt == BP_DELAY → RUN.
- **RUN**
  - Pop condition: bp_tvalid & ma_tvalid & d2_tvalid, with no pop in the current cycle. When it holds, a registered pop asserts all three treadys and aligned_valid for exactly one cycle.
  - The cycle after a pop is never itself a pop cycle.
  - Skew counter:
    - increments each cycle that some but not all valids are high;
    - clears when all three or none are high, and on every pop;
    - reaching SKEW_LIMIT → FAULT.
- **FAULT**
  - All treadys 0; skew_err=1.
  - enable=0 → IDLE.
- **Any state**
  - enable=0 → IDLE on the next edge.
  - Clears sample_cnt and the skew counter.
  - skew_err is not cleared; only reset clears it.
- **Output decoding**
  - treadys in IDLE/FILL/FAULT are a Moore decode of the registered state and sample_cnt.
  - In RUN, treadys equal the pop register.

## Timing
- **Reset values:** state=IDLE, all treadys=0, aligned_valid=0, skew_err=0, sample_cnt=0, pop=0, skew counter=0.
- **IDLE→FILL:** enable sampled high at edge N gives state=FILL at N. d2_tready and ma_tready are 1 from N.
- **Counting:** the source handshake sampled at edge N appears in sample_cnt after N.
- **MA hold:** once sample_cnt reaches BP_DELAY−MA_DELAY (307), ma_tready is 0 in that same cycle.
- **FILL→RUN:** sample_cnt==BP_DELAY at edge N gives state=RUN after N+1.
- **Pop latency:** all valids seen at edge N → treadys and aligned_valid high during cycle N+1 → low in cycle N+2, regardless of valids.
- **enable drop:** enable falling during a pop cycle does not cancel the pop in progress. The state is IDLE on the following edge.
- **Simultaneous events:** if reset and enable are both 1, reset wins. If a source handshake coincides with the FILL→RUN transition, it is not counted.

## Structure
- **Package `phase_align_pkg`:**
  - state enum (IDLE, FILL, RUN, FAULT, 2-bit encoding as above);
  - default constants BP_DELAY_DEF=350, MA_DELAY_DEF=43, SKEW_LIMIT_DEF=1000.
- **Sub-module `skew_watchdog`:** saturating partial-valid counter with a clear input and a limit-reached output.
- **Top:** FSM, sample counter and pop register.

## Test plan
Parameters are BP_DELAY=350 and MA_DELAY=43 unless stated.

1. **Reset values.** Hold reset 3 cycles with all valids=1 → all outputs 0, state=0.
2. **Priming.** Set enable=1 and send 350 source handshakes, each followed by one idle cycle.
   - ma_tready falls when sample_cnt=307.
   - bp_tready stays 0 throughout FILL.
   - d2_tready stays 1 throughout FILL.
   - state=2 one cycle after sample_cnt=350.
3. **Lockstep pop.** In RUN, raise all three valids in the same cycle and hold them.
   - aligned_valid pulses every second cycle.
   - The treadys match aligned_valid exactly.
   - 10 pops take 20 cycles.
4. **Staggered valids.** In RUN: BP valid at cycle 0, MA at cycle 3, D2 at cycle 5 → single pop in cycle 6; skew counter cleared.
5. **Skew fault.** In RUN, hold only bp_tvalid=1 for 1000 cycles.
   - state=3 and skew_err=1.
   - treadys 0.
   - enable=0 → state=0 with skew_err still 1.
6. **Abort mid-FILL.** Drop enable at sample_cnt=200, then re-enable → sample_cnt restarts at 0 and ma_tready=1 again.

Source files
------------

// File: rtl/phase_align_pkg.sv
// -----------------------------------------------------------------------------
// phase_align_pkg
// Shared definitions for the ECG stream phase-alignment controller:
//   - state_t        : controller FSM state (IDLE=0, FILL=1, RUN=2, FAULT=3)
//   - *_DEF          : default delays and skew tolerance used by the top level
// -----------------------------------------------------------------------------
package phase_align_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam int BP_DELAY_DEF   = 350;
   localparam int MA_DELAY_DEF   = 43;
   localparam int SKEW_LIMIT_DEF = 1000;

endpackage

// File: rtl/phase_align_ctrl_skew_watchdog.sv
// -----------------------------------------------------------------------------
// skew_watchdog
// Counts consecutive cycles in which only some of the aligned streams present
// valid data. The count saturates at LIMIT.
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high
//   clear     in   forces the count to zero on the next edge (has priority)
//   partial   in   some but not all stream valids are high this cycle
//   limit_hit out  this cycle is the one that makes the count reach LIMIT
// -----------------------------------------------------------------------------
module skew_watchdog
   import phase_align_pkg::*;
#(
   parameter int LIMIT = SKEW_LIMIT_DEF,
   parameter int W     = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic partial,
   output logic limit_hit
);

   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (partial && (count != LIMIT_V)) begin
         count <= count + 1'b1;
      end
   end

   // Flag the edge on which the count reaches LIMIT, so the owner can react
   // on that same edge rather than one cycle later.
   assign limit_hit = partial && !clear && (count == (LIMIT_V - 1'b1));

endmodule

// File: rtl/phase_align_ctrl.sv
// -----------------------------------------------------------------------------
// phase_align_ctrl
// Primes and then pops the BP, MA and D2 output FIFOs of the ECG chain so that
// BP lags D2 by BP_DELAY samples and MA lags D2 by MA_DELAY samples. After
// priming, the three heads are consumed together as one aligned triple.
//
// Handshake rule (all AXI-stream style ports): a transfer happens on a rising
// edge of sys_clock where tvalid and tready are both 1; tready may be driven
// independently of tvalid, and tvalid is never used to derive tready within
// the same cycle.
//
// Ports:
//   sys_clock      in   clock
//   reset          in   synchronous, active-high
//   enable         in   1 = run alignment, 0 = return to IDLE
//   src_tvalid/    in   monitor of the ADC sample stream feeding the filters
//   src_tready
//   bp_tvalid      in   BP FIFO valid          bp_tready  out  BP FIFO ready
//   ma_tvalid      in   MA FIFO valid          ma_tready  out  MA FIFO ready
//   d2_tvalid      in   D2 FIFO valid          d2_tready  out  D2 FIFO ready
//   aligned_valid  out  one-cycle pulse, aligned triple being consumed
//   state          out  current FSM state
//   skew_err       out  sticky, set on entry to FAULT, cleared by reset only
//   sample_cnt     out  source handshakes counted while in FILL
// -----------------------------------------------------------------------------
module phase_align_ctrl
   import phase_align_pkg::*;
#(
   parameter int BP_DELAY   = BP_DELAY_DEF,
   parameter int MA_DELAY   = MA_DELAY_DEF,
   parameter int CNT_W      = 10,
   parameter int SKEW_LIMIT = SKEW_LIMIT_DEF,
   parameter int SKEW_W     = 10
) (
   input  logic             sys_clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             src_tvalid,
   input  logic             src_tready,
   input  logic             bp_tvalid,
   output logic             bp_tready,
   input  logic             ma_tvalid,
   output logic             ma_tready,
   input  logic             d2_tvalid,
   output logic             d2_tready,
   output logic             aligned_valid,
   output logic [1:0]       state,
   output logic             skew_err,
   output logic [CNT_W-1:0] sample_cnt
);

   localparam logic [CNT_W-1:0] BP_CNT  = CNT_W'(BP_DELAY);
   // MA stops popping once this many samples are in, leaving MA_DELAY behind.
   localparam logic [CNT_W-1:0] MA_HOLD = CNT_W'(BP_DELAY - MA_DELAY);

   state_t           state_q;
   state_t           state_d;
   logic             pop_q;
   logic             pop_d;
   logic [CNT_W-1:0] cnt_q;
   logic             all_v;
   logic             any_v;
   logic             skew_clear;
   logic             skew_hit;

   assign all_v = bp_tvalid & ma_tvalid & d2_tvalid;
   assign any_v = bp_tvalid | ma_tvalid | d2_tvalid;

   // The watchdog only runs while aligned streams are being consumed; a pop
   // cycle always restarts it, even if the FIFOs look partial right after.
   assign skew_clear = !enable || (state_q != RUN) || pop_q || all_v || !any_v;

   skew_watchdog #(
      .LIMIT (SKEW_LIMIT),
      .W     (SKEW_W)
   ) u_skew_watchdog (
      .clk       (sys_clock),
      .reset     (reset),
      .clear     (skew_clear),
      .partial   (any_v & ~all_v),
      .limit_hit (skew_hit)
   );

   // State register and pop register
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         state_q <= IDLE;
         pop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pop_q   <= pop_d;
      end
   end

   // Next state, pop request and ready/valid decode
   always_comb begin
      state_d       = state_q;
      pop_d         = 1'b0;
      bp_tready     = 1'b0;
      ma_tready     = 1'b0;
      d2_tready     = 1'b0;
      aligned_valid = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable) state_d = FILL;
         end
         FILL: begin
            d2_tready = 1'b1;
            ma_tready = (cnt_q < MA_HOLD);
            if (cnt_q == BP_CNT) state_d = RUN;
         end
         RUN: begin
            bp_tready     = pop_q;
            ma_tready     = pop_q;
            d2_tready     = pop_q;
            aligned_valid = pop_q;
            // A pop is a single cycle; the cycle after never re-pops so the
            // FIFOs can update their valids first.
            pop_d         = all_v && !pop_q;
            if (skew_hit) state_d = FAULT;
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (!enable) begin
         state_d = IDLE;
         pop_d   = 1'b0;
      end
   end

   // Sample counter: counts only in FILL, saturates at BP_DELAY, so a
   // handshake on the FILL->RUN edge is not counted.
   always_ff @(posedge sys_clock) begin
      if (reset || !enable) begin
         cnt_q <= '0;
      end else if ((state_q == FILL) && src_tvalid && src_tready && (cnt_q != BP_CNT)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         skew_err <= 1'b0;
      end else if ((state_q != FAULT) && (state_d == FAULT)) begin
         skew_err <= 1'b1;
      end
   end

   assign state      = state_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_phase_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phase_align_ctrl
// Randomized bench for phase_align_ctrl with a cycle-level behavioural model
// and a per-cycle compare process, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_phase_align_ctrl;

   localparam int BP    = 350;
   localparam int MA    = 43;
   localparam int LIMIT = 1000;
   localparam int CNT_W = 10;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic             enable;
   logic             src_tvalid;
   logic             src_tready;
   logic             bp_tvalid;
   logic             ma_tvalid;
   logic             d2_tvalid;
   logic             bp_tready;
   logic             ma_tready;
   logic             d2_tready;
   logic             aligned_valid;
   logic             skew_err;
   logic [1:0]       state;
   logic [CNT_W-1:0] sample_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   phase_align_ctrl #(
      .BP_DELAY   (BP),
      .MA_DELAY   (MA),
      .CNT_W      (CNT_W),
      .SKEW_LIMIT (LIMIT),
      .SKEW_W     (10)
   ) dut (
      .sys_clock     (clk),
      .reset         (reset),
      .enable        (enable),
      .src_tvalid    (src_tvalid),
      .src_tready    (src_tready),
      .bp_tvalid     (bp_tvalid),
      .bp_tready     (bp_tready),
      .ma_tvalid     (ma_tvalid),
      .ma_tready     (ma_tready),
      .d2_tvalid     (d2_tvalid),
      .d2_tready     (d2_tready),
      .aligned_valid (aligned_valid),
      .state         (state),
      .skew_err      (skew_err),
      .sample_cnt    (sample_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Mode numbers: 0 idle, 1 filling, 2 running, 3 faulted.
   int  m_mode    = 0;
   int  m_count   = 0;   // handshakes taken while filling
   int  m_partial = 0;   // consecutive partial-valid cycles while running
   bit  m_popping = 1'b0;
   bit  m_err     = 1'b0;
   bit  chk_en    = 1'b0;

   always @(posedge clk) begin : model_step
      int nv;
      nv = int'(bp_tvalid) + int'(ma_tvalid) + int'(d2_tvalid);
      if (reset) begin
         m_mode = 0; m_count = 0; m_partial = 0; m_popping = 0; m_err = 0;
      end else if (!enable) begin
         m_mode = 0; m_count = 0; m_partial = 0; m_popping = 0;
      end else begin
         case (m_mode)
            0: m_mode = 1;
            1: begin
               if (m_count == BP) m_mode = 2;
               else if (src_tvalid && src_tready) m_count = m_count + 1;
            end
            2: begin
               if (m_popping) begin
                  m_popping = 0; m_partial = 0;
               end else if (nv == 3) begin
                  m_popping = 1; m_partial = 0;
               end else if (nv == 0) begin
                  m_partial = 0;
               end else begin
                  m_partial = m_partial + 1;
                  if (m_partial == LIMIT) begin
                     m_mode = 3; m_err = 1;
                  end
               end
            end
            default: ;
         endcase
      end
      chk_en = 1'b1;
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin : compare
      int e_bp, e_ma, e_d2;
      if (chk_en) begin
         e_bp = (m_mode == 2) ? int'(m_popping) : 0;
         e_d2 = (m_mode == 1) ? 1 : e_bp;
         e_ma = (m_mode == 1) ? int'(m_count < BP - MA) : e_bp;
         check("state",         state,         m_mode);
         check("sample_cnt",    sample_cnt,    m_count);
         check("skew_err",      skew_err,      m_err);
         check("aligned_valid", aligned_valid, (m_mode == 2) ? m_popping : 1'b0);
         check("bp_tready",     bp_tready,     e_bp);
         check("ma_tready",     ma_tready,     e_ma);
         check("d2_tready",     d2_tready,     e_d2);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic src_idle();
      int r;
      r = $urandom_range(0, 2);
      src_tvalid = (r == 1);
      src_tready = (r == 2);
   endtask

   task automatic set_valids(input bit b, input bit m, input bit d);
      bp_tvalid = b;
      ma_tvalid = m;
      d2_tvalid = d;
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int pulses;
      int r;

      // Reset with everything asserted: reset must win over enable.
      reset = 1; enable = 1; src_tvalid = 1; src_tready = 1;
      set_valids(1, 1, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state", state, 0);
      check("rst_bp", bp_tready, 0);
      check("rst_ma", ma_tready, 0);
      check("rst_d2", d2_tready, 0);
      check("rst_av", aligned_valid, 0);
      check("rst_err", skew_err, 0);
      check("rst_cnt", sample_cnt, 0);

      tick();
      reset = 0; enable = 0; src_tvalid = 0; src_tready = 0;
      set_valids(0, 0, 0);
      tick();
      enable = 1;
      tick();
      @(negedge clk);
      check("fill_entry_state", state, 1);
      check("fill_entry_ma", ma_tready, 1);
      check("fill_entry_d2", d2_tready, 1);

      // Abort mid-fill at 200 handshakes.
      for (int k = 1; k <= 200; k++) begin
         src_tvalid = 1; src_tready = 1;
         tick();
         src_idle();
         tick();
      end
      @(negedge clk);
      check("abort_cnt200", sample_cnt, 200);
      enable = 0;
      tick();
      @(negedge clk);
      check("abort_state", state, 0);
      check("abort_cnt", sample_cnt, 0);
      check("abort_ma", ma_tready, 0);
      enable = 1;
      tick();
      @(negedge clk);
      check("refill_state", state, 1);
      check("refill_cnt", sample_cnt, 0);
      check("refill_ma", ma_tready, 1);

      // Priming: 350 handshakes each followed by an idle cycle.
      for (int k = 1; k <= BP; k++) begin
         src_tvalid = 1; src_tready = 1;
         tick();
         @(negedge clk);
         check("prime_cnt", sample_cnt, k);
         check("prime_bp", bp_tready, 0);
         check("prime_d2", d2_tready, 1);
         if (k == 306) check("prime_ma306", ma_tready, 1);
         if (k == 307) check("prime_ma307", ma_tready, 0);
         if (k == BP) begin
            check("prime_state350", state, 1);
            // Handshake coinciding with FILL->RUN must not be counted.
            src_tvalid = 1; src_tready = 1;
         end else begin
            src_idle();
         end
         tick();
      end
      @(negedge clk);
      check("run_state", state, 2);
      check("run_cnt_held", sample_cnt, BP);
      src_tvalid = 0; src_tready = 0;

      // Lockstep pops: 10 pops in 20 cycles.
      set_valids(1, 1, 1);
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         @(negedge clk);
         pulses += int'(aligned_valid);
         check("lock_av_parity", aligned_valid, (c % 2 == 0));
      end
      check("lock_pulses", pulses, 10);

      // Staggered valids: BP at 0, MA at 3, D2 at 5 -> one pop seen after edge 5.
      set_valids(0, 0, 0);
      tick();
      tick();
      for (int c = 0; c < 9; c++) begin
         if (c < 6) set_valids(1, c >= 3, c >= 5);
         else       set_valids(0, 0, 0);
         tick();
         @(negedge clk);
         check("stagger_av", aligned_valid, (c == 5));
      end

      // Random valids while running.
      for (int c = 0; c < 1500; c++) begin
         r = $urandom_range(0, 3);
         if (r == 0)      set_valids(0, 0, 0);
         else if (r == 1) set_valids(1, 1, 1);
         else             set_valids($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         tick();
      end

      // Skew fault: only BP valid for 1000 cycles.
      set_valids(0, 0, 0);
      tick();
      tick();
      set_valids(1, 0, 0);
      for (int i = 1; i <= LIMIT; i++) begin
         tick();
         @(negedge clk);
         if (i == LIMIT - 1) check("skew_still_run", state, 2);
         if (i == LIMIT) begin
            check("skew_state", state, 3);
            check("skew_err_set", skew_err, 1);
            check("skew_bp", bp_tready, 0);
            check("skew_ma", ma_tready, 0);
            check("skew_d2", d2_tready, 0);
         end
      end
      enable = 0;
      tick();
      @(negedge clk);
      check("fault_exit_state", state, 0);
      check("fault_err_sticky", skew_err, 1);

      // Re-prime quickly, then drop enable during a pop cycle.
      set_valids(0, 0, 0);
      enable = 1;
      tick();
      src_tvalid = 1; src_tready = 1;
      repeat (BP + 2) tick();
      src_tvalid = 0; src_tready = 0;
      @(negedge clk);
      check("reprime_state", state, 2);
      set_valids(1, 1, 1);
      tick();
      @(negedge clk);
      check("drop_pop_av", aligned_valid, 1);
      enable = 0;
      tick();
      @(negedge clk);
      check("drop_state", state, 0);
      check("drop_av", aligned_valid, 0);

      // Fully random phase: occasional reset and enable drops.
      for (int c = 0; c < 4000; c++) begin
         reset  = ($urandom_range(0, 499) == 0);
         enable = ($urandom_range(0, 299) != 0);
         src_tvalid = $urandom_range(0, 3) != 0;
         src_tready = $urandom_range(0, 3) != 0;
         r = $urandom_range(0, 3);
         if (r == 0)      set_valids(0, 0, 0);
         else if (r == 1) set_valids(1, 1, 1);
         else             set_valids($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         tick();
      end
      reset = 0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
